// File: rtl/clk_switch_pkg.sv
// Shared types and reset constants for the glitch-free clock switch controller.
package clk_switch_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_UPDATE = 2'd2,
    ST_ARM    = 2'd3
  } state_t;

  localparam logic DEFAULT_SEL    = 1'b1;
  localparam int   DEFAULT_FACTOR = 0;

endpackage

// File: rtl/clk_switch_ctrl_div.sv
// Divided-clock channel: counter, factor register and registered toggle output.
// A synchronous load reloads the factor and forces counter and output to zero.
module clk_div_channel
  import clk_switch_pkg::*;
#(
  parameter int FACTOR_W = 3,
  parameter int CNT_W    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [FACTOR_W-1:0] factor_in,
  output logic                clk_div,
  output logic                clk_div_next
);

  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_next;
  logic [FACTOR_W-1:0] factor;
  logic [FACTOR_W-1:0] factor_next;

  // clk_div_next is exported so the parent can register clk_out in phase with clk_div.
  always_comb begin
    factor_next  = factor;
    cnt_next     = cnt + CNT_W'(1);
    clk_div_next = clk_div;
    if (load) begin
      factor_next  = factor_in;
      cnt_next     = '0;
      clk_div_next = 1'b0;
    end else if (cnt == CNT_W'(factor)) begin
      cnt_next     = '0;
      clk_div_next = ~clk_div;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      factor  <= FACTOR_W'(DEFAULT_FACTOR);
      cnt     <= '0;
      clk_div <= 1'b0;
    end else begin
      factor  <= factor_next;
      cnt     <= cnt_next;
      clk_div <= clk_div_next;
    end
  end

endmodule

// File: rtl/clk_switch_ctrl.sv
// Glitch-free clock switch / divider reconfiguration controller.
// Optional CLK_SWITCH_STATUS_EN adds the sw_count completed-switch counter.
module clk_switch_ctrl
  import clk_switch_pkg::*;
#(
  parameter int FACTOR_W = 3,
  parameter int CNT_W    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  // cfg handshake: a configuration transfers on a posedge where cfg_valid && cfg_ready;
  // the source holds cfg_* stable while cfg_valid is high and cfg_ready is low.
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic                cfg_sel,
  input  logic [FACTOR_W-1:0] cfg_div_a,
  input  logic [FACTOR_W-1:0] cfg_div_b,
  output logic                clk_a,
  output logic                clk_b,
  output logic                clk_out,
  output logic                sw_done,
  output logic                busy,
`ifdef CLK_SWITCH_STATUS_EN
  output logic [7:0]          sw_count,
`endif
  output state_t              state_dbg
);

  state_t              state;
  state_t              state_next;
  logic                sel_q;
  logic                sel_next;
  logic                gate_q;
  logic                gate_next;
  logic                load;
  logic                sw_done_next;
  logic                pend_sel;
  logic [FACTOR_W-1:0] pend_a;
  logic [FACTOR_W-1:0] pend_b;
  logic                clk_a_next;
  logic                clk_b_next;
  logic                src;
  logic                src_next;

  clk_div_channel #(.FACTOR_W(FACTOR_W), .CNT_W(CNT_W)) u_chan_a (
    .clk          (clk),
    .rst_n        (rst_n),
    .load         (load),
    .factor_in    (pend_a),
    .clk_div      (clk_a),
    .clk_div_next (clk_a_next)
  );

  clk_div_channel #(.FACTOR_W(FACTOR_W), .CNT_W(CNT_W)) u_chan_b (
    .clk          (clk),
    .rst_n        (rst_n),
    .load         (load),
    .factor_in    (pend_b),
    .clk_div      (clk_b),
    .clk_div_next (clk_b_next)
  );

  assign cfg_ready = (state == ST_RUN);
  assign busy      = ~cfg_ready;
  assign state_dbg = state;
  assign src       = sel_q ? clk_a : clk_b;
  assign src_next  = sel_next ? clk_a_next : clk_b_next;

  // The gate only changes while the selected source is low, so no runt pulse escapes.
  always_comb begin
    state_next   = state;
    sel_next     = sel_q;
    gate_next    = gate_q;
    load         = 1'b0;
    sw_done_next = 1'b0;
    case (state)
      ST_RUN: begin
        gate_next = enable ? (gate_q | ~src) : (gate_q & src);
        if (cfg_valid) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!src) begin
          gate_next  = 1'b0;
          state_next = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        load       = 1'b1;
        sel_next   = pend_sel;
        state_next = ST_ARM;
      end
      ST_ARM: begin
        gate_next    = enable;
        sw_done_next = 1'b1;
        state_next   = ST_RUN;
      end
      default: state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_RUN;
      sel_q    <= DEFAULT_SEL;
      gate_q   <= 1'b0;
      clk_out  <= 1'b0;
      sw_done  <= 1'b0;
      pend_sel <= DEFAULT_SEL;
      pend_a   <= FACTOR_W'(DEFAULT_FACTOR);
      pend_b   <= FACTOR_W'(DEFAULT_FACTOR);
    end else begin
      state   <= state_next;
      sel_q   <= sel_next;
      gate_q  <= gate_next;
      clk_out <= gate_next & src_next;
      sw_done <= sw_done_next;
      if (cfg_valid && cfg_ready) begin
        pend_sel <= cfg_sel;
        pend_a   <= cfg_div_a;
        pend_b   <= cfg_div_b;
      end
    end
  end

`ifdef CLK_SWITCH_STATUS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) sw_count <= 8'd0;
    else if (sw_done) sw_count <= sw_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// Directed bench for clk_switch_ctrl: a scoreboard of expected sw_done cycles and
// high-pulse widths, plus inline checks of reset, gating and handshake behaviour.
module tb_clk_switch_ctrl;
  import clk_switch_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       cfg_sel = 1'b0;
  logic [2:0] cfg_div_a = 3'd0;
  logic [2:0] cfg_div_b = 3'd0;
  logic       cfg_ready, clk_a, clk_b, clk_out, sw_done, busy;
  state_t     state_dbg;
`ifdef CLK_SWITCH_STATUS_EN
  logic [7:0] sw_count;
`endif

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          hi_len = 0;
  int          exp_hi = 1;
  int          acc_cyc = 0;
  bit          mon_en = 1'b1;
  logic [19:0] mon_e;
  logic [19:0] exp_q[$];

  clk_switch_ctrl #(.FACTOR_W(3), .CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_sel   (cfg_sel),
    .cfg_div_a (cfg_div_a),
    .cfg_div_b (cfg_div_b),
    .clk_a     (clk_a),
    .clk_b     (clk_b),
    .clk_out   (clk_out),
    .sw_done   (sw_done),
    .busy      (busy),
`ifdef CLK_SWITCH_STATUS_EN
    .sw_count  (sw_count),
`endif
    .state_dbg (state_dbg)
  );

  // clock / cycle count
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_rise(input bit use_a, input string name);
    logic prev, cur;
    int n;
    n = 0;
    cur = use_a ? clk_a : clk_b;
    do begin
      prev = cur;
      tick(1);
      n++;
      cur = use_a ? clk_a : clk_b;
    end while (!(cur && !prev) && n < 64);
    check({name, "_rise_wait"}, int'(cur && !prev), 1);
  endtask

  task automatic wait_out(input logic level, input string name);
    int n;
    n = 0;
    while (clk_out !== level && n < 64) begin
      tick(1);
      n++;
    end
    check({name, "_out_wait"}, int'(clk_out === level), 1);
  endtask

  // Offers one configuration; k = extra drain cycles, new_hi = clk_out high width after the switch.
  task automatic send_cfg(input logic sel, input logic [2:0] da, input logic [2:0] db,
                          input int k, input int new_hi, input bit expect_done);
    int n;
    n = 0;
    cfg_sel = sel;
    cfg_div_a = da;
    cfg_div_b = db;
    cfg_valid = 1'b1;
    while (!cfg_ready && n < 64) begin
      tick(1);
      n++;
    end
    check("cfg_ready_at_offer", int'(cfg_ready), 1);
    tick(1);
    acc_cyc = cyc;
    cfg_valid = 1'b0;
    if (expect_done) exp_q.push_back({16'(acc_cyc + 3 + k), 4'(new_hi)});
  endtask

  // monitor: high-pulse widths and sw_done scoreboard
  always @(negedge clk) begin
    if (!rst_n || !mon_en) hi_len = 0;
    else if (clk_out) hi_len++;
    else if (hi_len > 0) begin
      check("clk_out_high_width", hi_len, exp_hi);
      hi_len = 0;
    end
    if (rst_n && sw_done) begin
      check("sw_done_pending", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("sw_done_cycle", cyc, int'(mon_e[19:4]));
        exp_hi = int'(mon_e[3:0]);
      end
    end
  end

  initial begin
    int t1, t2, base, hi_cnt, a_cnt, busy_cnt, n;

    tick(3);
    check("rst_clk_out", int'(clk_out), 0);
    check("rst_clk_a", int'(clk_a), 0);
    check("rst_clk_b", int'(clk_b), 0);
    check("rst_sw_done", int'(sw_done), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_cfg_ready", int'(cfg_ready), 1);
    check("rst_state", int'(state_dbg), int'(ST_RUN));

    // defaults: divide-by-2 on channel A, clk_out follows it
    rst_n = 1'b1;
    enable = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick(1);
      check("default_clk_a", int'(clk_a), i % 2);
      check("default_clk_out", int'(clk_out), i % 2);
    end
    check("default_cfg_ready", int'(cfg_ready), 1);

    // switch 1: to channel B, factor 3; best-case timing
    wait_rise(1'b1, "sw1");
    send_cfg(1'b0, 3'd0, 3'd3, 0, 4, 1'b1);
    base = acc_cyc;
    check("sw1_drain", int'(state_dbg), int'(ST_DRAIN));
    tick(1);
    check("sw1_update", int'(state_dbg), int'(ST_UPDATE));
    tick(1);
    check("sw1_arm", int'(state_dbg), int'(ST_ARM));
    tick(1);
    check("sw1_run", int'(cfg_ready), 1);
    wait_out(1'b1, "sw1_first");
    t1 = cyc;
    check("sw1_first_high", t1 - base, 6);
    wait_out(1'b0, "sw1_fall");
    wait_out(1'b1, "sw1_second");
    t2 = cyc;
    check("sw1_period", t2 - t1, 8);

    // switch 2: to channel A factor 7, offered just after the B rising phase
    wait_rise(1'b0, "sw2");
    send_cfg(1'b1, 3'd7, 3'd3, 3, 8, 1'b1);
    base = acc_cyc;
    tick(3);
    check("sw2_still_drain", int'(state_dbg), int'(ST_DRAIN));
    tick(1);
    check("sw2_update", int'(state_dbg), int'(ST_UPDATE));
    wait_out(1'b1, "sw2_first");
    check("sw2_first_high", cyc - base, 13);

    // switch 3: channel A factor 2, drained from an 8-cycle high phase
    wait_rise(1'b1, "sw3");
    send_cfg(1'b1, 3'd2, 3'd3, 7, 3, 1'b1);
    base = acc_cyc;
    n = 0;
    while (!cfg_ready && n < 64) begin
      tick(1);
      n++;
    end
    check("sw3_ready_return", cyc - base, 10);

    // drop enable mid-high: one more high sample, then closed while clk_a keeps running
    wait_rise(1'b1, "en_drop");
    tick(1);
    enable = 1'b0;
    hi_cnt = 0;
    a_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      hi_cnt += int'(clk_out);
      a_cnt += int'(clk_a);
    end
    check("disabled_out_highs", hi_cnt, 1);
    check("disabled_clk_a_highs", a_cnt, 6);

    // re-raise during a high phase: resumes at the following rising phase only
    wait_rise(1'b1, "en_raise");
    base = cyc;
    enable = 1'b1;
    tick(1);
    check("reenable_hold_low", int'(clk_out), 0);
    wait_out(1'b1, "reenable");
    check("reenable_first_high", cyc - base, 6);

    // hold cfg_valid through the busy period: exactly one accept
    wait_rise(1'b1, "hold");
    cfg_sel = 1'b1;
    cfg_div_a = 3'd2;
    cfg_div_b = 3'd3;
    cfg_valid = 1'b1;
    tick(1);
    base = cyc;
    exp_q.push_back({16'(base + 5), 4'd3});
    busy_cnt = 0;
    n = 0;
    while (!cfg_ready && n < 32) begin
      busy_cnt += int'(busy);
      tick(1);
      n++;
    end
    cfg_valid = 1'b0;
    check("hold_ready_return", cyc - base, 5);
    check("hold_busy_cycles", busy_cnt, 5);
    tick(8);
    check("hold_idle_state", int'(state_dbg), int'(ST_RUN));
`ifdef CLK_SWITCH_STATUS_EN
    check("sw_count_after_four", int'(sw_count), 4);
`endif

    // reset in DRAIN abandons the pending switch
    wait_rise(1'b1, "rst_mid");
    send_cfg(1'b0, 3'd0, 3'd5, 2, 6, 1'b0);
    check("rst_mid_drain", int'(state_dbg), int'(ST_DRAIN));
    mon_en = 1'b0;
    rst_n = 1'b0;
    tick(1);
    check("rst_mid_state", int'(state_dbg), int'(ST_RUN));
    check("rst_mid_clk_out", int'(clk_out), 0);
    check("rst_mid_clk_b", int'(clk_b), 0);
    check("rst_mid_ready", int'(cfg_ready), 1);
`ifdef CLK_SWITCH_STATUS_EN
    check("rst_mid_sw_count", int'(sw_count), 0);
`endif
    rst_n = 1'b1;
    exp_hi = 1;
    mon_en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick(1);
      check("post_rst_clk_out", int'(clk_out), i % 2);
    end
    tick(6);
    check("no_pending_sw_done", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clk_switch_ctrl.md
# clk_switch_ctrl

Glitch-free clock switch and divider reconfiguration controller for the tiny-user clock block. Owns two divided-clock channels (A, B) and a registered output clock. Accepts new divide factors and channel selection through a valid/ready handshake, and applies them only at safe points. It drains the running channel to a low phase, gates it off, reloads the channels, and re-arms the output, so `clk_out` never produces a runt pulse.

## Interface
Parameters:
- `FACTOR_W`, 3: width of each divide factor.
- `CNT_W`, 4: width of each channel counter; must satisfy 2^CNT_W > 2^FACTOR_W.

Ports:
- `clk`  in  1: single system clock; all logic on posedge.
- `rst_n`  in  1: synchronous, active-low reset.
- `enable`  in  1: output enable; closes the gate glitch-free when low.
- `cfg_valid`  in  1: new configuration offered.
- `cfg_ready`  out  1: controller can accept a configuration (high only in RUN).
- `cfg_sel`  in  1: 1 selects channel A, 0 selects channel B.
- `cfg_div_a`  in  FACTOR_W: new channel A factor.
- `cfg_div_b`  in  FACTOR_W: new channel B factor.
- `clk_a`, `clk_b`  out  1: raw divided clocks (registered).
- `clk_out`  out  1: gated, selected clock (registered).
- `sw_done`  out  1: one-cycle pulse when a switch completes.
- `busy`  out  1: high in any state other than RUN.

## Operation
- Channel: the counter increments each cycle. When counter == factor, the output toggles and the counter clears. Half period is factor+1 cycles; full period is 2·(factor+1). Factor 0 gives a divide-by-2.
- `src` = sel_q ? clk_a : clk_b. `clk_out` <= gate_next & src_next. `clk_out` is therefore aligned with `clk_a`/`clk_b`.
- Gate rule in RUN: gate_q <= enable ? (gate_q | ~src) : (gate_q & src). The gate opens or closes only while `src` is low.
- FSM states and transitions:
  - RUN: cfg_ready=1. On cfg_valid & cfg_ready, latch cfg_sel/div_a/div_b into pending registers and go to DRAIN.
  - DRAIN: on an edge where src==0, set gate_q<=0 and go to UPDATE. Otherwise hold, keeping the gate unchanged.
  - UPDATE: sel_q<=pending sel; both factors load from pending; both counters <=0; clk_a, clk_b <=0; go to ARM.
  - ARM: gate_q<=enable; go to RUN; sw_done<=1.
- `cfg_valid` seen while not in RUN is ignored. The source holds its values until ready; this is standard valid/ready.
- `enable` low in DRAIN, UPDATE or ARM does not alter the sequence. ARM leaves the gate closed.
- Reset: state RUN, sel_q=1, factors=0, counters=0, clk_a=clk_b=0, gate_q=0, clk_out=0, sw_done=0, busy=0, cfg_ready=1 (once rst_n is high).

## Timing
- Accept at edge T. DRAIN occupies T+1 … T+1+k, where k is the number of cycles until src is sampled low; k ≤ factor+1 of the old channel.
- Best case: UPDATE at T+2, ARM at T+3, RUN with cfg_ready=1 and sw_done=1 at T+4.
- First `clk_out` high occurs factor_new+1 cycles after UPDATE, provided enable=1.
- Reset mid-switch abandons the pending configuration and returns all state to reset values on the next edge.
- Counter wrap is impossible, because clear happens at counter == factor ≤ 2^FACTOR_W−1.

## Configuration
- `CLK_SWITCH_STATUS_EN`:
  - Defined: adds output `sw_count` [7:0], an 8-bit count of completed switches. It increments on sw_done, wraps 255→0 and resets to 0.
  - Undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- Shared package `clk_switch_pkg`: the state enum (RUN, DRAIN, UPDATE, ARM) and the default-factor/default-select constants.
- Sub-module `clk_div_channel`: counter, factor register, toggle output and synchronous load/clear input. It is instantiated twice.

## Test plan
- Reset, then enable=1 with defaults: clk_a toggles every cycle; clk_out follows clk_a; cfg_ready=1.
- Accept sel=0, div_b=3 while clk_a is low: UPDATE at T+2, sw_done at T+4; clk_out period is 8 cycles and never high for fewer than 4 cycles.
- Accept sel=1, div_a=7 while the old source (div_b=3) has just gone high: DRAIN lasts 4 cycles; no clk_out pulse is shorter than 4 cycles.
- Drop enable mid-high-phase of div 2: clk_out completes its 3-cycle high, then stays 0. Re-raise enable during the high phase: clk_out resumes at the next rising phase only.
- Hold cfg_valid with busy=1: no second accept until cfg_ready returns; exactly one sw_done per accept.
- Assert rst_n=0 in DRAIN: next cycle state is RUN, sel_q=1, clk_out=0, sw_count=0 (with `CLK_SWITCH_STATUS_EN`).
